// File: rtl/core_fetch_stage_pkg.sv
// Shared definitions for the RV32I fetch stage: state encoding and default constants.
package core_fetch_stage_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT
  } fetch_state_t;

endpackage

// File: rtl/core_fetch_stage_flopenrc.sv
// Enabled flop with synchronous clear and asynchronous reset; clear wins over enable.
module flopenrc #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= RESET_VAL;
    else if (clear) q <= CLEAR_VAL;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/core_fetch_stage.sv
// Instruction-fetch stage with variable-latency imem handshake and the F-D pipeline register.
module core_fetch_stage
  import core_fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_f,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               pc_src_d,
  input  logic [INSTR_W-1:0] pc_target_d,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rd_data,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] instr_d,
  output logic [INSTR_W-1:0] pc_d,
  output logic [INSTR_W-1:0] pc_plus4_d,
  output logic               valid_d,
  output logic               fetch_busy
);

  localparam logic [INSTR_W-1:0] PC_STEP = 32'd4;

  fetch_state_t       state;
  logic [INSTR_W-1:0] pc_f;
  logic [INSTR_W-1:0] pc_plus4_f;
  logic [INSTR_W-1:0] redirect_pc;
  logic               redirect_pending;
  logic               accept;
  logic               take;
  logic               load_d;
  logic               bubble_d;

  assign imem_addr  = pc_f;
  assign pc_plus4_f = pc_f + PC_STEP;
  assign fetch_busy = imem_req & ~imem_valid;
  assign accept     = imem_req & imem_valid & ~stall_f;

  // A response is only forwarded to D when it is on the correct path.
  assign take     = accept & ~redirect_pending & ~pc_src_d;
  assign load_d   = take & ~flush_d & ~stall_d;
  assign bubble_d = flush_d | (~stall_d & ~take);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= BOOT;
      imem_req         <= 1'b0;
      pc_f             <= RESET_PC;
      redirect_pending <= 1'b0;
      redirect_pc      <= '0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          imem_req <= 1'b1;
        end
        RUN:     if (!imem_valid) state <= WAIT;
        WAIT:    if (imem_valid)  state <= RUN;
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase

      // The redirect latch can only fire without a response, so it never collides with accept.
      if (!stall_f) begin
        if (accept && redirect_pending) begin
          pc_f             <= redirect_pc;
          redirect_pending <= 1'b0;
        end else if (accept && pc_src_d) begin
          pc_f <= pc_target_d;
        end else if (accept) begin
          pc_f <= pc_plus4_f;
        end else if (pc_src_d && imem_req && !imem_valid) begin
          redirect_pc      <= pc_target_d;
          redirect_pending <= 1'b1;
        end
      end
    end
  end

  flopenrc #(.WIDTH(INSTR_W), .RESET_VAL(NOP_INSTR), .CLEAR_VAL(NOP_INSTR)) u_instr_d (
    .clk(clk), .reset(reset), .en(load_d), .clear(bubble_d), .d(imem_rd_data), .q(instr_d)
  );

  flopenrc #(.WIDTH(1), .RESET_VAL(1'b0), .CLEAR_VAL(1'b0)) u_valid_d (
    .clk(clk), .reset(reset), .en(load_d), .clear(bubble_d), .d(1'b1), .q(valid_d)
  );

  flopenrc #(.WIDTH(INSTR_W), .RESET_VAL('0), .CLEAR_VAL('0)) u_pc_d (
    .clk(clk), .reset(reset), .en(load_d), .clear(1'b0), .d(pc_f), .q(pc_d)
  );

  flopenrc #(.WIDTH(INSTR_W), .RESET_VAL('0), .CLEAR_VAL('0)) u_pc_plus4_d (
    .clk(clk), .reset(reset), .en(load_d), .clear(1'b0), .d(pc_plus4_f), .q(pc_plus4_d)
  );

endmodule

// File: tb/tb_core_fetch_stage.sv
// Self-checking bench for core_fetch_stage: directed vector table, reset/wrap sequences, random vs. model.
module tb_core_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_f = 1'b0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        pc_src_d = 1'b0;
  logic [31:0] pc_target_d = '0;
  logic        imem_valid = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd_data;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        fetch_busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          sf, sd, fl, ps, iv;
    logic [31:0] tgt;
    bit          e_req, e_busy, e_vd;
    logic [31:0] e_addr, e_pc, e_p4, e_instr;
  } vec_t;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  assign imem_rd_data = word_of(imem_addr);

  core_fetch_stage dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_d(pc_src_d), .pc_target_d(pc_target_d), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rd_data(imem_rd_data), .imem_valid(imem_valid),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .fetch_busy(fetch_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit sf, sd, fl, ps, input logic [31:0] tgt, input bit iv,
                              input bit req, busy, input logic [31:0] addr,
                              input bit vd, input logic [31:0] pc, p4);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fl = fl; v.ps = ps; v.tgt = tgt; v.iv = iv;
    v.e_req = req; v.e_busy = busy; v.e_addr = addr;
    v.e_vd = vd; v.e_pc = pc; v.e_p4 = p4;
    v.e_instr = vd ? word_of(pc) : NOP;
    return v;
  endfunction

  // Called at a falling edge: drive, check fetch-side outputs, clock, check D-side outputs.
  task automatic apply(input vec_t v, input string tag);
    stall_f = v.sf; stall_d = v.sd; flush_d = v.fl;
    pc_src_d = v.ps; pc_target_d = v.tgt; imem_valid = v.iv;
    #1;
    chk({tag, "_req"},  32'(imem_req),   32'(v.e_req));
    chk({tag, "_addr"}, imem_addr,       v.e_addr);
    chk({tag, "_busy"}, 32'(fetch_busy), 32'(v.e_busy));
    @(posedge clk);
    #1;
    chk({tag, "_instr_d"}, instr_d,       v.e_instr);
    chk({tag, "_pc_d"},    pc_d,          v.e_pc);
    chk({tag, "_pc4_d"},   pc_plus4_d,    v.e_p4);
    chk({tag, "_valid_d"}, 32'(valid_d),  32'(v.e_vd));
    @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req"},     32'(imem_req),   32'd0);
    chk({tag, "_addr"},    imem_addr,       32'd0);
    chk({tag, "_busy"},    32'(fetch_busy), 32'd0);
    chk({tag, "_instr_d"}, instr_d,         NOP);
    chk({tag, "_pc_d"},    pc_d,            32'd0);
    chk({tag, "_pc4_d"},   pc_plus4_d,      32'd0);
    chk({tag, "_valid_d"}, 32'(valid_d),    32'd0);
  endtask

  initial begin
    vec_t tbl[$];
    bit          m_run, m_pend, m_vd;
    logic [31:0] m_pc, m_rpc, m_instr, m_pcd, m_p4;
    bit          acc, take;

    //         sf sd fl ps tgt            iv req bsy addr           vd pc_d           pc4_d
    tbl.push_back(mk(0,0,0,0,32'h0,        1, 0,0, 32'h0,         0, 32'h0,        32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,        1, 1,0, 32'h0,         1, 32'h0,        32'h4));
    tbl.push_back(mk(0,0,0,0,32'h0,        1, 1,0, 32'h4,         1, 32'h4,        32'h8));
    tbl.push_back(mk(0,0,0,0,32'h0,        1, 1,0, 32'h8,         1, 32'h8,        32'hC));
    tbl.push_back(mk(0,0,0,0,32'h0,        1, 1,0, 32'hC,         1, 32'hC,        32'h10));
    tbl.push_back(mk(0,0,0,0,32'h0,        0, 1,1, 32'h10,        0, 32'hC,        32'h10));
    tbl.push_back(mk(0,0,0,0,32'h0,        0, 1,1, 32'h10,        0, 32'hC,        32'h10));
    tbl.push_back(mk(0,0,0,0,32'h0,        0, 1,1, 32'h10,        0, 32'hC,        32'h10));
    tbl.push_back(mk(0,0,0,0,32'h0,        1, 1,0, 32'h10,        1, 32'h10,       32'h14));
    tbl.push_back(mk(0,0,0,1,32'h100,      0, 1,1, 32'h14,        0, 32'h10,       32'h14));
    tbl.push_back(mk(0,0,0,0,32'h0,        0, 1,1, 32'h14,        0, 32'h10,       32'h14));
    tbl.push_back(mk(0,0,0,0,32'h0,        1, 1,0, 32'h14,        0, 32'h10,       32'h14));
    tbl.push_back(mk(0,0,0,0,32'h0,        1, 1,0, 32'h100,       1, 32'h100,      32'h104));
    tbl.push_back(mk(0,0,0,0,32'h0,        1, 1,0, 32'h104,       1, 32'h104,      32'h108));
    tbl.push_back(mk(0,0,0,1,32'h40,       1, 1,0, 32'h108,       0, 32'h104,      32'h108));
    tbl.push_back(mk(0,0,0,0,32'h0,        1, 1,0, 32'h40,        1, 32'h40,       32'h44));
    tbl.push_back(mk(1,1,0,0,32'h0,        1, 1,0, 32'h44,        1, 32'h40,       32'h44));
    tbl.push_back(mk(1,1,0,0,32'h0,        1, 1,0, 32'h44,        1, 32'h40,       32'h44));
    tbl.push_back(mk(1,1,1,0,32'h0,        1, 1,0, 32'h44,        0, 32'h40,       32'h44));
    tbl.push_back(mk(0,0,0,0,32'h0,        1, 1,0, 32'h44,        1, 32'h44,       32'h48));
    tbl.push_back(mk(0,0,0,1,32'hFFFF_FFFC,1, 1,0, 32'h48,        0, 32'h44,       32'h48));
    tbl.push_back(mk(0,0,0,0,32'h0,        1, 1,0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,        1, 1,0, 32'h0,         1, 32'h0,        32'h4));
    tbl.push_back(mk(0,0,0,1,32'h200,      0, 1,1, 32'h4,         0, 32'h0,        32'h4));

    repeat (2) @(negedge clk);
    #1;
    chk_reset_values("rst0");
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // Last vector left a redirect to 0x200 pending in WAIT; reset between edges must drop it.
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pc_src_d = 1'b0; imem_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_reset_values("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    apply(mk(0,0,0,0,32'h0, 1, 0,0, 32'h0, 0, 32'h0, 32'h0), "post_boot");
    apply(mk(0,0,0,0,32'h0, 1, 1,0, 32'h0, 1, 32'h0, 32'h4), "post_f0");
    apply(mk(0,0,0,0,32'h0, 1, 1,0, 32'h4, 1, 32'h4, 32'h8), "post_f4");

    // Randomized phase against a behavioural model, from a fresh reset.
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    m_run = 0; m_pend = 0; m_pc = '0; m_rpc = '0;
    m_instr = NOP; m_pcd = '0; m_p4 = '0; m_vd = 0;

    for (int n = 0; n < 2000; n++) begin
      vec_t v;
      v.sf  = ($urandom_range(7) == 0);
      v.sd  = ($urandom_range(7) == 0);
      v.fl  = ($urandom_range(15) == 0);
      v.ps  = ($urandom_range(5) == 0);
      v.iv  = ($urandom_range(3) != 0);
      v.tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;

      v.e_req  = m_run;
      v.e_addr = m_pc;
      v.e_busy = m_run && !v.iv;

      acc  = m_run && v.iv && !v.sf;
      take = acc && !m_pend && !v.ps;

      if (v.fl || (!v.sd && !take)) begin
        m_instr = NOP;
        m_vd    = 0;
      end else if (!v.sd) begin
        m_instr = word_of(m_pc);
        m_pcd   = m_pc;
        m_p4    = m_pc + 32'd4;
        m_vd    = 1;
      end

      if (!v.sf) begin
        if (acc && m_pend) begin
          m_pc   = m_rpc;
          m_pend = 0;
        end else if (acc && v.ps) begin
          m_pc = v.tgt;
        end else if (acc) begin
          m_pc = m_pc + 32'd4;
        end else if (m_run && v.ps && !v.iv) begin
          m_rpc  = v.tgt;
          m_pend = 1;
        end
      end
      m_run = 1;

      v.e_vd = m_vd; v.e_pc = m_pcd; v.e_p4 = m_p4; v.e_instr = m_instr;
      apply(v, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
